mac_operand_sequencer: RTL and testbench

// - Upstream feeder for the MAC unit: holds one weight vector and one input vector in local

---
 rtl/mac_operand_sequencer_if.sv | 15 +
 rtl/mac_operand_sequencer.sv | 121 ++++++++++++
 tb/tb_mac_operand_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_sequencer_if.sv
// rtl/mac_operand_sequencer_if.sv - operand/accumulator bus between the sequencer and one MAC lane
// master = sequencer (drives operands and controls), slave = MAC (returns accumulator).
interface mac_operand_sequencer_if #(
  parameter int DW   = 4,
  parameter int ACCW = 8
);
  logic [DW-1:0]   mac_w;
  logic [DW-1:0]   mac_x;
  logic            mac_load;
  logic            mac_clear;
  logic [ACCW-1:0] mac_acc;

  modport master (output mac_w, mac_x, mac_load, mac_clear, input mac_acc);
  modport slave  (input mac_w, mac_x, mac_load, mac_clear, output mac_acc);
endinterface

// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - weight/input vector store that streams a dot product through one MAC lane
// Optional overflow flag via MAC_SEQ_OVF_EN (adds port ovf and a wide shadow sum).
module mac_operand_sequencer #(
  parameter int DW   = 4,
  parameter int N    = 4,
  parameter int ACCW = 8,
  localparam int AW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] result,
`ifdef MAC_SEQ_OVF_EN
  output logic            ovf,
`endif
  mac_operand_sequencer_if.master mac
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic [DW-1:0] wbank [N];
  logic [DW-1:0] xbank [N];
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic          wr_ok;

  assign idx_nxt = idx + AW'(1);
  // busy covers CLEAR..DONE, so the banks are frozen while the MAC is being fed
  assign wr_ok   = wr_en && !busy && ({1'b0, wr_addr} < (AW+1)'(N));

`ifdef MAC_SEQ_OVF_EN
  localparam int SW = ACCW + AW + 1;
  logic [SW-1:0] shadow;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      idx           <= '0;
      mac.mac_w     <= '0;
      mac.mac_x     <= '0;
      mac.mac_load  <= 1'b0;
      mac.mac_clear <= 1'b0;
      for (int i = 0; i < N; i++) begin
        wbank[i] <= '0;
        xbank[i] <= '0;
      end
`ifdef MAC_SEQ_OVF_EN
      shadow        <= '0;
      ovf           <= 1'b0;
`endif
    end else begin
      if (wr_ok) begin
        if (wr_sel) xbank[wr_addr] <= wr_data;
        else        wbank[wr_addr] <= wr_data;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_CLEAR;
            busy          <= 1'b1;
            mac.mac_clear <= 1'b1;
          end
        end
        S_CLEAR: begin
          state         <= S_STREAM;
          mac.mac_clear <= 1'b0;
          mac.mac_load  <= 1'b1;
          mac.mac_w     <= wbank[0];
          mac.mac_x     <= xbank[0];
          idx           <= '0;
`ifdef MAC_SEQ_OVF_EN
          shadow        <= '0;
`endif
        end
        S_STREAM: begin
`ifdef MAC_SEQ_OVF_EN
          shadow <= shadow + SW'(mac.mac_w) * SW'(mac.mac_x);
`endif
          // idx names the element currently on mac_w/mac_x
          if (idx == AW'(N - 1)) begin
            state        <= S_DRAIN;
            mac.mac_load <= 1'b0;
            mac.mac_w    <= '0;
            mac.mac_x    <= '0;
          end else begin
            idx       <= idx_nxt;
            mac.mac_w <= wbank[idx_nxt];
            mac.mac_x <= xbank[idx_nxt];
          end
        end
        S_DRAIN: begin
          state  <= S_DONE;
          done   <= 1'b1;
          result <= mac.mac_acc;
`ifdef MAC_SEQ_OVF_EN
          ovf    <= |shadow[SW-1:ACCW];
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb/tb_mac_operand_sequencer.sv - scoreboard bench for mac_operand_sequencer with a behavioural MAC lane
// Build with MAC_SEQ_OVF_EN defined to also check ovf.
module tb_mac_operand_sequencer;
  localparam int DW = 4, N = 4, ACCW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [1:0]      wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            busy, done;
  logic [ACCW-1:0] result;
`ifdef MAC_SEQ_OVF_EN
  logic            ovf;
`endif

  mac_operand_sequencer_if #(.DW(DW), .ACCW(ACCW)) mac_bus ();

  mac_operand_sequencer #(.DW(DW), .N(N), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .result(result),
`ifdef MAC_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .mac(mac_bus.master)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 mac_bus.mac_acc <= '0;
    else if (mac_bus.mac_clear) mac_bus.mac_acc <= '0;
    else if (mac_bus.mac_load)
      mac_bus.mac_acc <= mac_bus.mac_acc + {4'b0, mac_bus.mac_w} * {4'b0, mac_bus.mac_x};
  end

  typedef struct { int res; int ovf; } exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0, n_acc = 0, done_cnt = 0;
  int clr_cnt = 0, ld_cnt = 0, gap = 0;
  logic [DW-1:0] gw [N] = '{4'd15, 4'd3, 4'd5, 4'd8};
  logic [DW-1:0] gx [N] = '{4'd15, 4'd2, 4'd3, 4'd1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      clr_cnt = 0; ld_cnt = 0; gap = 0;
    end else begin
      if (mac_bus.mac_clear) clr_cnt++;
      if (mac_bus.mac_load) begin ld_cnt++; gap = 0; end else gap++;
      if (done) begin
        done_cnt++;
        chk("expect_pending_at_done", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", int'(result), e.res);
`ifdef MAC_SEQ_OVF_EN
          chk("ovf", int'(ovf), e.ovf);
`endif
          chk("clear_cycles", clr_cnt, 1);
          chk("load_cycles", ld_cnt, N);
          chk("done_after_drain", gap, 2);
        end
        clr_cnt = 0; ld_cnt = 0;
      end
    end
  end

  task automatic wr(input logic sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 2'(addr); wr_data = DW'(data);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_vecs(input int wv, input int xv, input logic golden);
    for (int i = 0; i < N; i++) begin
      wr(1'b0, i, golden ? int'(gw[i]) : wv);
      wr(1'b1, i, golden ? int'(gx[i]) : xv);
    end
  endtask

  task automatic expect_run(input int res, input int o);
    exp_t e;
    e.res = res; e.ovf = o;
    exp_q.push_back(e);
    n_acc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    errors++; checks++;
    $display("FAIL done_timeout: got no done expected done within 60 cycles");
  endtask

  task automatic wait_load();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mac_bus.mac_load) return;
    end
    errors++; checks++;
    $display("FAIL load_timeout: got no mac_load expected mac_load within 20 cycles");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_load", int'(mac_bus.mac_load), 0);
    chk("rst_clear", int'(mac_bus.mac_clear), 0);
    chk("rst_w", int'(mac_bus.mac_w), 0);
    chk("rst_x", int'(mac_bus.mac_x), 0);
`ifdef MAC_SEQ_OVF_EN
    chk("rst_ovf", int'(ovf), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // golden vectors: 225+6+15+8
    load_vecs(0, 0, 1'b1);
    expect_run(254, 0); pulse_start(); wait_done();

    // all 15: 900 mod 256
    load_vecs(15, 15, 1'b0);
    expect_run(132, 1); pulse_start(); wait_done();

    // write while busy must not reach the bank
    load_vecs(0, 0, 1'b1);
    expect_run(254, 0); pulse_start(); wait_load();
    wr(1'b0, 2, 7);
    wait_done();
    @(posedge clk); #1;
    expect_run(254, 0); pulse_start(); wait_done();

    // start mid-STREAM and during DONE are both dropped
    @(posedge clk); #1;
    expect_run(254, 0); pulse_start(); wait_load();
    pulse_start();
    wait_done();
    pulse_start();
    repeat (12) @(posedge clk);
    #1;
    chk("idle_after_ignored_starts", int'(busy), 0);

    // async reset during STREAM
    pulse_start(); wait_load();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_load", int'(mac_bus.mac_load), 0);
    chk("arst_clear", int'(mac_bus.mac_clear), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_vecs(0, 0, 1'b1);
    expect_run(254, 0); pulse_start(); wait_done();

    // back-to-back: second start in the cycle right after done
    @(posedge clk); #1;
    expect_run(254, 0); pulse_start(); wait_done();
    @(posedge clk); #1;
    expect_run(254, 0); pulse_start(); wait_done();

    // write and start together: w[0]=1 is used, 15+6+15+8
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 4'd1; start = 1'b1;
    expect_run(44, 0);
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    chk("pending_expectations", exp_q.size(), 0);
    chk("done_pulses", done_cnt, n_acc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
